debug_unit: RTL and testbench

Sequencer that owns the MIPS pipeline from the outside world. It loads the instruction memory from UART bytes and starts the processor in continuous or single-step mode. It counts executed cycles and, on halt or after each step, streams PC, cycle count and the 32 registers back over UART. It sits in `top` between the UART rx/tx cores and the pipeline's enable, reset, instruction-memory write port and debug read mux.

---
 rtl/debug_unit.sv | 170 +++++++++++++++++
 tb/tb_debug_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// debug_unit: UART-driven instruction loader, run/step controller and
// PC/cycle/register dump sequencer for the MIPS pipeline.
module debug_unit #(
    parameter int LEN       = 32,
    parameter int IMEM_ADDR = 10,
    parameter int N_DUMP    = 34
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_done,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_done,
    output logic                 imem_we,
    output logic [IMEM_ADDR-1:0] imem_addr,
    output logic [LEN-1:0]       imem_data,
    output logic                 cpu_enable,
    output logic                 cpu_reset,
    input  logic                 halt,
    output logic [5:0]           dbg_sel,
    input  logic [LEN-1:0]       dbg_data
);
    typedef enum logic [3:0] {
        IDLE, LOAD, RUN, STEP_WAIT, STEP_EXEC, DUMP_SEL, DUMP_CAP, DUMP_TX, DUMP_WAIT
    } state_t;

    localparam logic [5:0] LAST = 6'(N_DUMP - 1);

    state_t                 state_q, state_d;
    logic                   ret_step_q, ret_step_d;
    logic [1:0]             bcnt_q, bcnt_d;
    logic [5:0]             idx_q, idx_d;
    logic [LEN-1:0]         word_q, word_d;
    logic [LEN-1:0]         cap_q, cap_d;
    logic [LEN-1:0]         cycle_q, cycle_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   imem_we_q, imem_we_d;
    logic [IMEM_ADDR-1:0]   imem_addr_q, imem_addr_d;
    logic [LEN-1:0]         imem_data_q, imem_data_d;
    logic                   cpu_en_q, cpu_en_d;
    logic                   cpu_rst_q, cpu_rst_d;

    always_comb begin
        state_d     = state_q;
        ret_step_d  = ret_step_q;
        bcnt_d      = bcnt_q;
        idx_d       = idx_q;
        word_d      = word_q;
        cap_d       = cap_q;
        cycle_d     = cycle_q + LEN'(cpu_en_q);
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q + IMEM_ADDR'(imem_we_q);
        imem_data_d = imem_data_q;
        cpu_en_d    = 1'b0;
        cpu_rst_d   = 1'b0;
        case (state_q)
            IDLE: if (rx_done) begin
                if (rx_data == 8'h4C) begin
                    state_d     = LOAD;
                    imem_addr_d = '0;
                    bcnt_d      = '0;
                end else if (rx_data == 8'h43 || rx_data == 8'h53) begin
                    state_d   = (rx_data == 8'h43) ? RUN : STEP_WAIT;
                    cpu_rst_d = 1'b1;
                    cycle_d   = '0;
                end
            end
            LOAD: if (rx_done) begin
                word_d = {rx_data, word_q[LEN-1:8]};
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    imem_we_d   = 1'b1;
                    imem_data_d = word_d;
                    state_d     = (&word_d) ? IDLE : LOAD;
                end
            end
            RUN: begin
                // halt seen during the reset cycle belongs to the previous program
                cpu_en_d = 1'b1;
                if (halt && !cpu_rst_q) begin
                    cpu_en_d   = 1'b0;
                    ret_step_d = 1'b0;
                    state_d    = DUMP_SEL;
                end
            end
            STEP_WAIT: if (rx_done) begin
                if (rx_data == 8'h4E) begin
                    state_d  = STEP_EXEC;
                    cpu_en_d = 1'b1;
                end else if (rx_data == 8'h51) begin
                    state_d = IDLE;
                end
            end
            STEP_EXEC: begin
                ret_step_d = !halt;
                state_d    = DUMP_SEL;
            end
            DUMP_SEL: state_d = DUMP_CAP;
            DUMP_CAP: begin
                cap_d   = (idx_q == 6'd1) ? cycle_q : dbg_data;
                state_d = DUMP_TX;
            end
            DUMP_TX: begin
                tx_data_d  = 8'(cap_q >> {bcnt_q, 3'b000});
                tx_start_d = 1'b1;
                state_d    = DUMP_WAIT;
            end
            DUMP_WAIT: if (tx_done && !tx_start_q) begin
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q != 2'd3) begin
                    state_d = DUMP_TX;
                end else if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = ret_step_q ? STEP_WAIT : IDLE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = DUMP_SEL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ret_step_q  <= 1'b0;
            bcnt_q      <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            cap_q       <= '0;
            cycle_q     <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            cpu_en_q    <= 1'b0;
            cpu_rst_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_step_q  <= ret_step_d;
            bcnt_q      <= bcnt_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            cap_q       <= cap_d;
            cycle_q     <= cycle_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_q   <= cpu_rst_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_data  = imem_data_q;
    assign cpu_enable = cpu_en_q;
    assign cpu_reset  = cpu_rst_q;
    assign dbg_sel    = idx_q;
endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit: directed load/run/step/dump scenarios against a UART tx
// responder and a registered debug-mux model.
module tb_debug_unit;
    localparam int LEN = 32, IMEM_ADDR = 10, N_DUMP = 34;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7:0]           rx_data;
    logic                 rx_done;
    logic [7:0]           tx_data;
    logic                 tx_start;
    logic                 tx_done;
    logic                 imem_we;
    logic [IMEM_ADDR-1:0] imem_addr;
    logic [LEN-1:0]       imem_data;
    logic                 cpu_enable;
    logic                 cpu_reset;
    logic                 halt;
    logic [5:0]           dbg_sel;
    logic [LEN-1:0]       dbg_data;

    int n_chk = 0, n_bad = 0, n_tx = 0, n_extra = 0, n_unstable = 0;
    int n_we = 0, n_en = 0, n_rst = 0, tx_delay = 1;
    int t0, e0, r0, c;
    logic                 last_we;
    logic [7:0]           txb [0:1023];
    logic [IMEM_ADDR-1:0] we_addr [0:15];
    logic [LEN-1:0]       we_data [0:15];

    always #5 clk = ~clk;

    debug_unit #(.LEN(LEN), .IMEM_ADDR(IMEM_ADDR), .N_DUMP(N_DUMP)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done),
        .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .cpu_enable(cpu_enable), .cpu_reset(cpu_reset), .halt(halt),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    // register file stand-in: r0 slot reads 0xDEADBEEF, others 0xC0DE00<sel>
    always @(posedge clk)
        dbg_data <= (dbg_sel == 6'd2) ? 32'hDEADBEEF : (32'hC0DE0000 | {26'b0, dbg_sel});

    always @(negedge clk) begin
        if (imem_we && n_we < 16) begin
            we_addr[n_we] <= imem_addr;
            we_data[n_we] <= imem_data;
            n_we <= n_we + 1;
        end
        if (cpu_enable) n_en <= n_en + 1;
        if (cpu_reset) n_rst <= n_rst + 1;
    end

    initial begin
        logic [7:0] b;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                b = tx_data;
                if (n_tx < 1024) txb[n_tx] = b;
                n_tx++;
                for (int k = 0; k < tx_delay; k++) begin
                    @(negedge clk);
                    if (tx_start) n_extra++;
                    if (tx_data !== b) n_unstable++;
                end
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        last_we = imem_we;
        rx_done = 1'b0;
        tick(2);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (n_tx < n && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    function automatic logic [31:0] txw(input int i);
        return {txb[i+3], txb[i+2], txb[i+1], txb[i]};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; rx_data = '0; rx_done = 1'b0; halt = 1'b0;
        tick(3);
        chk("reset_outputs", {tx_data, tx_start, imem_we, imem_addr, imem_data,
                              cpu_enable, cpu_reset, dbg_sel}, '0);
        reset = 1'b1;
        tick(2);

        send(8'h4C); send(8'h01); send(8'h00); send(8'h00);
        chk("we_not_early", last_we, 0);
        send(8'h20);
        chk("we_after_4th", last_we, 1);
        send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
        tick(2);
        chk("load_we_count", n_we, 2);
        chk("load_addr0", we_addr[0], 0);
        chk("load_data0", we_data[0], 32'h20000001);
        chk("load_addr1", we_addr[1], 1);
        chk("load_data1", we_data[1], 32'hFFFFFFFF);
        chk("load_addr_inc", imem_addr, 2);
        send(8'h11); send(8'h11); send(8'h11); send(8'h11);
        chk("idle_after_load", n_we, 2);

        r0 = n_rst; e0 = n_en; t0 = n_tx; c = 0;
        send(8'h43);
        while (n_en - e0 < 10 && c < 100) begin tick(1); c++; end
        halt = 1'b1;
        wait_tx(t0 + 136, 3000);
        tick(20);
        halt = 1'b0;
        chk("run_bytes", n_tx - t0, 136);
        chk("run_cpu_reset", n_rst - r0, 1);
        chk("run_enable_cycles", n_en - e0, 10);
        chk("run_pc_word", txw(t0), 32'hC0DE0000);
        chk("run_cycle_word", txw(t0 + 4), 10);
        chk("run_r0_word", txw(t0 + 8), 32'hDEADBEEF);
        chk("run_last_word", txw(t0 + 132), 32'hC0DE0021);

        r0 = n_rst; e0 = n_en; t0 = n_tx;
        send(8'h53); send(8'h4E);
        wait_tx(t0 + 136, 3000);
        tick(5);
        send(8'h4E);
        wait_tx(t0 + 272, 3000);
        tick(5);
        send(8'h51); send(8'h4E);
        tick(20);
        chk("step_bytes", n_tx - t0, 272);
        chk("step_cpu_reset", n_rst - r0, 1);
        chk("step_enables", n_en - e0, 2);
        chk("step_cnt1", txw(t0 + 4), 1);
        chk("step_cnt2", txw(t0 + 140), 2);

        e0 = n_en; t0 = n_tx;
        send(8'h53);
        halt = 1'b1;
        send(8'h4E);
        wait_tx(t0 + 136, 3000);
        tick(5);
        halt = 1'b0;
        send(8'h4E);
        tick(20);
        chk("halt_step_bytes", n_tx - t0, 136);
        chk("halt_step_enables", n_en - e0, 1);
        chk("halt_step_cnt", txw(t0 + 4), 1);

        tx_delay = 50; t0 = n_tx;
        send(8'h53); send(8'h4E);
        wait_tx(t0 + 136, 10000);
        tick(60);
        send(8'h51);
        tx_delay = 1;
        chk("hs_bytes", n_tx - t0, 136);
        chk("hs_extra_start", n_extra, 0);
        chk("hs_tx_stable", n_unstable, 0);
        chk("hs_lsb_first", txb[t0 + 8], 8'hEF);
        chk("hs_word_order", txw(t0 + 8), 32'hDEADBEEF);

        send(8'h4C); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'hAA); send(8'hBB);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("async_reset_addr", imem_addr, 0);
        tick(2);
        reset = 1'b1;
        tick(2);
        send(8'h4C); send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        tick(3);
        chk("mid_we_count", n_we, 4);
        chk("mid_first_word", we_data[2], 32'h04030201);
        chk("mid_new_addr", we_addr[3], 0);
        chk("mid_new_data", we_data[3], 32'h11223344);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
